// File: rtl/hrm_uart_pkg.sv
// rtl/hrm_uart_pkg.sv - FSM encoding, channel indices and guard length for the UART transmit arbiter
//
// Shared by tx_arbiter:
//   tx_state_t  : arbiter FSM state encoding
//   CH_CPU      : channel index of the CPU outbox (channel 0)
//   CH_DBG      : channel index of the debug/status source (channel 1)
//   GUARD_LEN   : cycles after the write strobe during which busy is ignored
//   ch_onehot() : channel index -> one-hot grant vector

package hrm_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_SEND  = 3'd2,
    ST_GUARD = 3'd3,
    ST_WAIT  = 3'd4
  } tx_state_t;

  localparam logic CH_CPU = 1'b0;
  localparam logic CH_DBG = 1'b1;

  localparam int unsigned GUARD_LEN = 1;

  function automatic logic [1:0] ch_onehot(input logic ch);
    return (ch == CH_DBG) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - two-channel round-robin byte arbiter feeding a single UART transmitter
//
// Channel 0 is the CPU outbox, channel 1 a debug/status source that emits
// framed messages. Each byte is popped from its show-ahead FIFO, held in
// o_tx_data and strobed into the UART one cycle later. With LOCK_EN=1 a
// channel 1 frame, once started, is sent to its last byte before channel 0
// may interleave.
//
// Ports:
//   clk         in   system clock, rising edge
//   i_rst       in   asynchronous active-high reset
//   i_empty_n0  in   channel 0 holds at least one byte
//   i_data0     in   channel 0 head byte (show-ahead)
//   o_pop0      out  one-cycle pop of channel 0 head byte
//   i_empty_n1  in   channel 1 holds at least one byte
//   i_data1     in   channel 1 head byte (show-ahead)
//   i_last1     in   channel 1 head byte closes its frame
//   o_pop1      out  one-cycle pop of channel 1 head byte
//   i_busy_n    in   UART transmitter idle
//   o_tx_wr     out  one-cycle write strobe to the UART
//   o_tx_data   out  registered byte being sent
//   o_grant     out  one-hot owner of the current byte, 00 when idle

module tx_arbiter
  import hrm_uart_pkg::*;
#(
  parameter int DW      = 8,
  parameter int LOCK_EN = 1
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_empty_n0,
  input  logic [DW-1:0] i_data0,
  output logic          o_pop0,
  input  logic          i_empty_n1,
  input  logic [DW-1:0] i_data1,
  input  logic          i_last1,
  output logic          o_pop1,
  input  logic          i_busy_n,
  output logic          o_tx_wr,
  output logic [DW-1:0] o_tx_data,
  output logic [1:0]    o_grant
);

  localparam logic [1:0] GUARD_LAST = 2'(GUARD_LEN - 1);

  tx_state_t     state_q, state_d;
  logic          sel_q, sel_d;          // channel of the byte in flight
  logic          rr_q, rr_d;            // channel served most recently
  logic          lock_q, lock_d;        // channel 1 frame in progress
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    guard_cnt_q, guard_cnt_d;

  logic          req0;
  logic          req1;
  logic          any_req;
  logic          pick;

  // Request qualification and channel choice for the IDLE decision.
  // While locked, channel 0 is masked so an empty channel 1 stalls the
  // arbiter instead of letting channel 0 break into the frame.
  always_comb begin
    req0    = i_empty_n0 & ~lock_q;
    req1    = i_empty_n1;
    any_req = req0 | req1;
    pick    = CH_CPU;
    if (req0 && req1) begin
      pick = ~rr_q;
    end else if (req1) begin
      pick = CH_DBG;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_d        = rr_q;
    lock_d      = lock_q;
    tx_data_d   = tx_data_q;
    grant_d     = grant_q;
    guard_cnt_d = guard_cnt_q;
    o_pop0      = 1'b0;
    o_pop1      = 1'b0;
    o_tx_wr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Choice, byte and grant are captured here so they are already
        // stable during the pop cycle and unaffected by later requests.
        if (i_busy_n && any_req) begin
          sel_d     = pick;
          tx_data_d = (pick == CH_DBG) ? i_data1 : i_data0;
          grant_d   = ch_onehot(pick);
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Pops are gated by the empty flags so a misbehaving source can
        // never be popped while empty.
        o_pop0 = (sel_q == CH_CPU) && i_empty_n0;
        o_pop1 = (sel_q == CH_DBG) && i_empty_n1;
        rr_d   = sel_q;
        if ((LOCK_EN != 0) && (sel_q == CH_DBG)) begin
          lock_d = ~i_last1;
        end
        state_d = ST_SEND;
      end

      ST_SEND: begin
        o_tx_wr     = 1'b1;
        guard_cnt_d = '0;
        state_d     = ST_GUARD;
      end

      ST_GUARD: begin
        // The UART only raises busy a cycle after the strobe, so busy_n
        // is not trusted until the guard has elapsed.
        if (guard_cnt_q == GUARD_LAST) begin
          state_d = ST_WAIT;
        end else begin
          guard_cnt_d = guard_cnt_q + 2'd1;
        end
      end

      ST_WAIT: begin
        if (i_busy_n) begin
          grant_d = 2'b00;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset leaves rr pointing at channel 1 so channel 0 wins the first tie.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= CH_CPU;
      rr_q        <= CH_DBG;
      lock_q      <= 1'b0;
      tx_data_q   <= '0;
      grant_q     <= 2'b00;
      guard_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      tx_data_q   <= tx_data_d;
      grant_q     <= grant_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  assign o_tx_data = tx_data_q;
  assign o_grant   = grant_q;

endmodule
